// File: rtl/sgdma_descriptor_ram_pkg.sv
// sgdma_descriptor_ram_pkg: shared types and helpers for the SGDMA descriptor store
package sgdma_desc_pkg;
  typedef enum logic [1:0] {IDLE_RST, CLEAR, READY} state_e;
  function automatic int desc_word_bytes(input int data_w);
    return data_w / 8;
  endfunction
  function automatic logic [7:0] byte_merge(input logic [7:0] pri, input logic pri_en, input logic [7:0] sec);
    return pri_en ? pri : sec;
  endfunction
endpackage

// File: rtl/sgdma_descriptor_ram_if.sv
// sgdma_descriptor_ram_if: one Avalon-MM slave port of the descriptor store
interface sgdma_descriptor_ram_if
  import sgdma_desc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11
);
  logic [ADDR_W-1:0] address;
  logic [desc_word_bytes(DATA_W)-1:0] byteenable;
  logic chipselect;
  logic read;
  logic write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic readdatavalid;
  logic waitrequest;
  modport master(output address, byteenable, chipselect, read, write, writedata,
                 input readdata, readdatavalid, waitrequest);
  modport slave(input address, byteenable, chipselect, read, write, writedata,
                output readdata, readdatavalid, waitrequest);
endinterface

// File: rtl/sgdma_descriptor_ram_rd_pipe.sv
// sgdma_desc_rd_pipe: fixed-latency read data/valid shift register, data holds between strobes
module sgdma_desc_rd_pipe #(
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [LATENCY:0]   vld_in;
  logic [DATA_W-1:0]  dat_q [LATENCY];
  logic [DATA_W-1:0]  dat_d [LATENCY];
  logic [DATA_W-1:0]  dat_in [LATENCY+1];
  // shift valid every cycle; a data stage only loads when a valid word enters it
  always_comb begin
    vld_in = {vld_q, in_valid};
    dat_in[0] = in_data;
    for (int i = 0; i < LATENCY; i++) dat_in[i+1] = dat_q[i];
    for (int i = 0; i < LATENCY; i++) dat_d[i] = vld_in[i] ? dat_in[i] : dat_q[i];
    vld_d = vld_in[LATENCY-1:0];
  end
  // reset flushes in-flight reads so no strobe escapes after reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) dat_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < LATENCY; i++) dat_q[i] <= dat_d[i];
    end
  end
  assign out_valid = vld_in[LATENCY];
  assign out_data  = dat_in[LATENCY];
endmodule

// File: rtl/sgdma_descriptor_ram.sv
// sgdma_descriptor_ram: dual-port byte-enabled descriptor store with clear-on-reset sequencer
module sgdma_descriptor_ram
  import sgdma_desc_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 11,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic clk,
  input  logic reset_n,
  sgdma_descriptor_ram_if.slave s1,
  sgdma_descriptor_ram_if.slave s2,
  output logic init_done
);
  localparam int NB    = desc_word_bytes(DATA_W);
  localparam int DEPTH = 1 << ADDR_W;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              wait_q, wait_d;
  logic              done_q, done_d;
  logic              w1, w2, r1, r2, hit1, hit2;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd1_word, rd2_word, rd1_data, rd2_data;
  // sequencer: one idle cycle after reset, optional zero sweep, then ready until reset
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    done_d  = done_q;
    if (state_q == IDLE_RST) begin
      state_d = CLEAR_ON_RESET != 0 ? CLEAR : READY;
      cnt_d   = '0;
      wait_d  = CLEAR_ON_RESET != 0;
      done_d  = CLEAR_ON_RESET == 0;
    end else if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) begin
        state_d = READY;
        wait_d  = 1'b0;
        done_d  = 1'b1;
      end
    end
  end
  // state and registered handshake outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE_RST;
      cnt_q   <= '0;
      wait_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      done_q  <= done_d;
    end
  end
  assign w1   = done_q & s1.chipselect & s1.write;
  assign w2   = done_q & s2.chipselect & s2.write;
  assign r1   = done_q & s1.chipselect & s1.read & ~s1.write;
  assign r2   = done_q & s2.chipselect & s2.read & ~s2.write;
  assign hit1 = w2 && s2.address == s1.address;
  assign hit2 = w1 && s1.address == s2.address;
  // storage: clear sweep, else byte-lane writes with s1 applied last so it owns shared lanes
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) mem[cnt_q] <= '0;
    for (int b = 0; b < NB; b++) begin
      if (w2 && s2.byteenable[b]) mem[s2.address][8*b +: 8] <= s2.writedata[8*b +: 8];
      if (w1 && s1.byteenable[b]) mem[s1.address][8*b +: 8] <= s1.writedata[8*b +: 8];
    end
  end
  assign rd1_word = mem[s1.address];
  assign rd2_word = mem[s2.address];
  for (genvar i = 0; i < NB; i++) begin : g_fwd
    assign rd1_data[8*i +: 8] = byte_merge(s2.writedata[8*i +: 8], hit1 && s2.byteenable[i], rd1_word[8*i +: 8]);
    assign rd2_data[8*i +: 8] = byte_merge(s1.writedata[8*i +: 8], hit2 && s1.byteenable[i], rd2_word[8*i +: 8]);
  end
  sgdma_desc_rd_pipe #(.DATA_W(DATA_W), .LATENCY(READ_LATENCY)) u_rd1 (
    .clk(clk), .reset_n(reset_n), .in_valid(r1), .in_data(rd1_data),
    .out_valid(s1.readdatavalid), .out_data(s1.readdata)
  );
  sgdma_desc_rd_pipe #(.DATA_W(DATA_W), .LATENCY(READ_LATENCY)) u_rd2 (
    .clk(clk), .reset_n(reset_n), .in_valid(r2), .in_data(rd2_data),
    .out_valid(s2.readdatavalid), .out_data(s2.readdata)
  );
  assign s1.waitrequest = wait_q;
  assign s2.waitrequest = wait_q;
  assign init_done      = done_q;
endmodule

// File: tb/tb_sgdma_descriptor_ram.sv
// tb_sgdma_descriptor_ram: table, directed and random checks of latency-1/2 instances against a word-array model
module tb_sgdma_descriptor_ram;
  localparam int DEPTH = 2048;
  localparam int CLR   = DEPTH + 1;
  typedef struct packed {
    logic cs, rd, wr;
    logic [10:0] addr;
    logic [3:0] be;
    logic [31:0] wd;
  } req_t;
  typedef struct {
    req_t r1, r2;
    logic c1, c2;
    logic [31:0] e1, e2;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic done_a, done_b, done_c;
  int checks = 0, errors = 0, rel_cnt = 0;
  logic [31:0] ref_mem [DEPTH];
  logic eb_v [2];
  logic [31:0] eb_d [2], la [2], lb [2];
  int sa [2], sb [2];
  vec_t tbl [16];
  always #5 clk = ~clk;
  sgdma_descriptor_ram_if #(.DATA_W(32), .ADDR_W(11)) a1(), a2(), b1(), b2();
  sgdma_descriptor_ram_if #(.DATA_W(32), .ADDR_W(4)) c1(), c2();
  assign {b1.chipselect, b1.read, b1.write, b1.address, b1.byteenable, b1.writedata} =
         {a1.chipselect, a1.read, a1.write, a1.address, a1.byteenable, a1.writedata};
  assign {b2.chipselect, b2.read, b2.write, b2.address, b2.byteenable, b2.writedata} =
         {a2.chipselect, a2.read, a2.write, a2.address, a2.byteenable, a2.writedata};
  assign {c1.chipselect, c1.read, c1.write, c1.address, c1.byteenable, c1.writedata} = '0;
  assign {c2.chipselect, c2.read, c2.write, c2.address, c2.byteenable, c2.writedata} = '0;
  sgdma_descriptor_ram #(.DATA_W(32), .ADDR_W(11), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .s1(a1), .s2(a2), .init_done(done_a));
  sgdma_descriptor_ram #(.DATA_W(32), .ADDR_W(11), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .s1(b1), .s2(b2), .init_done(done_b));
  sgdma_descriptor_ram #(.DATA_W(32), .ADDR_W(4), .READ_LATENCY(1), .CLEAR_ON_RESET(0)) dut_c (
    .clk(clk), .reset_n(reset_n), .s1(c1), .s2(c2), .init_done(done_c));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  function automatic req_t req_idle();
    return '0;
  endfunction
  function automatic req_t req_rd(input logic [10:0] a);
    return '{1'b1, 1'b1, 1'b0, a, 4'h0, 32'h0};
  endfunction
  function automatic req_t req_wr(input logic [10:0] a, input logic [3:0] be, input logic [31:0] wd);
    return '{1'b1, 1'b0, 1'b1, a, be, wd};
  endfunction
  function automatic req_t req_rand();
    req_t q;
    q.cs   = $urandom_range(0, 3) != 0;
    q.rd   = 1'($urandom);
    q.wr   = 1'($urandom);
    q.addr = 11'($urandom_range(0, 15));
    q.be   = 4'($urandom);
    q.wd   = $urandom;
    return q;
  endfunction

  // one clock: drive both ports, advance the model, then compare every output of every instance
  task automatic cycle(input req_t q1, input req_t q2);
    logic rdy, v1, v2;
    logic [31:0] n1, n2;
    rdy = reset_n && rel_cnt >= CLR;
    {a1.chipselect, a1.read, a1.write, a1.address, a1.byteenable, a1.writedata} = q1;
    {a2.chipselect, a2.read, a2.write, a2.address, a2.byteenable, a2.writedata} = q2;
    if (rdy) begin
      for (int b = 0; b < 4; b++) if (q2.cs && q2.wr && q2.be[b]) ref_mem[q2.addr][8*b +: 8] = q2.wd[8*b +: 8];
      for (int b = 0; b < 4; b++) if (q1.cs && q1.wr && q1.be[b]) ref_mem[q1.addr][8*b +: 8] = q1.wd[8*b +: 8];
    end
    v1 = rdy && q1.cs && q1.rd && !q1.wr;
    v2 = rdy && q2.cs && q2.rd && !q2.wr;
    n1 = ref_mem[q1.addr];
    n2 = ref_mem[q2.addr];
    @(posedge clk);
    #1;
    if (reset_n) rel_cnt++;
    if (v1) la[0] = n1;
    if (v2) la[1] = n2;
    if (eb_v[0]) lb[0] = eb_d[0];
    if (eb_v[1]) lb[1] = eb_d[1];
    chk("a_s1_valid", a1.readdatavalid, v1);
    chk("a_s2_valid", a2.readdatavalid, v2);
    chk("a_s1_data", a1.readdata, la[0]);
    chk("a_s2_data", a2.readdata, la[1]);
    chk("b_s1_valid", b1.readdatavalid, eb_v[0]);
    chk("b_s2_valid", b2.readdatavalid, eb_v[1]);
    chk("b_s1_data", b1.readdata, lb[0]);
    chk("b_s2_data", b2.readdata, lb[1]);
    chk("a_wait", {a1.waitrequest, a2.waitrequest}, {2{rel_cnt < CLR}});
    chk("b_wait", {b1.waitrequest, b2.waitrequest}, {2{rel_cnt < CLR}});
    chk("init_done_ab", {done_a, done_b}, {2{rel_cnt >= CLR}});
    chk("c_init", {done_c, c1.waitrequest, c2.waitrequest, c1.readdatavalid},
        {rel_cnt >= 1, rel_cnt < 1, rel_cnt < 1, 1'b0});
    sa[0] += int'(a1.readdatavalid);
    sa[1] += int'(a2.readdatavalid);
    sb[0] += int'(b1.readdatavalid);
    sb[1] += int'(b2.readdatavalid);
    eb_v[0] = v1;
    eb_v[1] = v2;
    eb_d[0] = n1;
    eb_d[1] = n2;
  endtask

  // assert reset mid-cycle, check immediate flush, hold a few cycles, release and wait out the clear
  task automatic do_reset();
    reset_n = 1'b0;
    rel_cnt = 0;
    eb_v = '{1'b0, 1'b0};
    la = '{32'h0, 32'h0};
    lb = '{32'h0, 32'h0};
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    #1;
    chk("rst_valid", {a1.readdatavalid, a2.readdatavalid, b1.readdatavalid, b2.readdatavalid}, 4'h0);
    chk("rst_data", {a1.readdata, b2.readdata}, 64'h0);
    chk("rst_wait", {a1.waitrequest, b2.waitrequest, done_a, done_b}, 4'b1100);
    for (int i = 0; i < 3; i++) cycle(req_idle(), req_idle());
    reset_n = 1'b1;
    for (int i = 0; i < CLR + 1 && rel_cnt < CLR; i++) cycle(req_rd(11'(i)), req_rd(11'h7ff));
    chk("clear_done", rel_cnt, CLR);
  endtask

  initial begin
    tbl[0]  = '{req_idle(), req_rd(11'h7ff), 1'b0, 1'b1, 32'h0, 32'h0};
    tbl[1]  = '{req_wr(11'h010, 4'hf, 32'hdeadbeef), req_idle(), 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[2]  = '{req_idle(), req_rd(11'h010), 1'b0, 1'b1, 32'h0, 32'hdeadbeef};
    tbl[3]  = '{req_wr(11'h020, 4'h3, 32'h11223344), req_wr(11'h020, 4'he, 32'haabbccdd), 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[4]  = '{req_rd(11'h020), req_idle(), 1'b1, 1'b0, 32'haabb3344, 32'h0};
    tbl[5]  = '{req_wr(11'h030, 4'hf, 32'hcafef00d), req_rd(11'h030), 1'b0, 1'b1, 32'h0, 32'hcafef00d};
    tbl[6]  = '{req_wr(11'h040, 4'h0, 32'hffffffff), req_idle(), 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[7]  = '{req_idle(), req_rd(11'h040), 1'b0, 1'b1, 32'h0, 32'h0};
    tbl[8]  = '{'{1'b1, 1'b1, 1'b1, 11'h050, 4'hf, 32'h12345678}, req_idle(), 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[9]  = '{req_rd(11'h050), req_idle(), 1'b1, 1'b0, 32'h12345678, 32'h0};
    tbl[10] = '{req_rd(11'h060), req_wr(11'h060, 4'hf, 32'h55667788), 1'b1, 1'b0, 32'h55667788, 32'h0};
    tbl[11] = '{req_rd(11'h060), req_idle(), 1'b1, 1'b0, 32'h55667788, 32'h0};
    tbl[12] = '{req_wr(11'h060, 4'hf, 32'h0), req_idle(), 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[13] = '{req_rd(11'h060), '{1'b0, 1'b1, 1'b0, 11'h010, 4'h0, 32'h0}, 1'b1, 1'b0, 32'h0, 32'h0};
    tbl[14] = '{req_idle(), req_wr(11'h070, 4'h5, 32'h11223344), 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[15] = '{req_rd(11'h010), req_rd(11'h070), 1'b1, 1'b1, 32'hdeadbeef, 32'h00220044};
    {a1.chipselect, a1.read, a1.write, a1.address, a1.byteenable, a1.writedata} = '0;
    {a2.chipselect, a2.read, a2.write, a2.address, a2.byteenable, a2.writedata} = '0;
    #2;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].r1, tbl[i].r2);
      if (i > 0 && tbl[i-1].c1) chk("tbl_b_s1", {b1.readdatavalid, b1.readdata}, {1'b1, tbl[i-1].e1});
      if (i > 0 && tbl[i-1].c2) chk("tbl_b_s2", {b2.readdatavalid, b2.readdata}, {1'b1, tbl[i-1].e2});
      if (tbl[i].c1) chk("tbl_a_s1", {a1.readdatavalid, a1.readdata}, {1'b1, tbl[i].e1});
      if (tbl[i].c2) chk("tbl_a_s2", {a2.readdatavalid, a2.readdata}, {1'b1, tbl[i].e2});
    end
    cycle(req_idle(), req_idle());
    chk("tbl_b_last", {b1.readdatavalid, b1.readdata, b2.readdatavalid, b2.readdata[15:0]},
        {1'b1, 32'hdeadbeef, 1'b1, 16'h0044});
    for (int i = 0; i < 8; i++) cycle(req_wr(11'(i), 4'hf, $urandom), req_wr(11'(i + 8), 4'hf, $urandom));
    sa = '{0, 0};
    sb = '{0, 0};
    for (int i = 0; i < 16; i++) cycle(req_rd(11'(i)), req_rd(11'(15 - i)));
    for (int i = 0; i < 2; i++) cycle(req_idle(), req_idle());
    chk("burst_a_strobes", {sa[0], sa[1]}, {32'd16, 32'd16});
    chk("burst_b_strobes", {sb[0], sb[1]}, {32'd16, 32'd16});
    for (int i = 0; i < 1500; i++) cycle(req_rand(), req_rand());
    for (int i = 0; i < 16; i++) cycle(req_wr(11'(i), 4'hf, 32'h5a5a0000 | i), req_idle());
    cycle(req_rd(11'h003), req_rd(11'h004));
    do_reset();
    for (int i = 0; i < DEPTH / 2; i++) cycle(req_rd(11'(2 * i)), req_rd(11'(2 * i + 1)));
    for (int i = 0; i < 2; i++) cycle(req_idle(), req_idle());
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
